// File: rtl/phy_stim_pkg.sv
// Shared constants for the multi-lane PHY stimulus source: pattern modes,
// controller state encodings and the 8-bit LFSR feedback taps.
package phy_stim_pkg;

   localparam logic [1:0] MODE_ALT  = 2'd0;
   localparam logic [1:0] MODE_INC  = 2'd1;
   localparam logic [1:0] MODE_LFSR = 2'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // x^8+x^6+x^5+x^4+1 as a mask over state bits [7],[5],[4],[3]
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/phy_lane_pattern.sv
// One lane of the stimulus source: a per-lane pattern generator and the
// registered lane word it presents on each word boundary.
module phy_lane_pattern
   import phy_stim_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               LANE      = 0,
   parameter logic [WIDTH-1:0] PAT_A     = 8'hAA,
   parameter logic [WIDTH-1:0] PAT_B     = 8'hBB,
   parameter logic [WIDTH-1:0] LANE_STEP = 8'h22,
   parameter logic [WIDTH-1:0] SEED      = 8'hA5
) (
   input  logic             clk_32f,
   input  logic             reset_L,
   input  logic             init,
   input  logic             step,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] data
);

   localparam logic [WIDTH-1:0] ALT_A     = PAT_A + WIDTH'(LANE) * LANE_STEP;
   localparam logic [WIDTH-1:0] ALT_B     = PAT_B + WIDTH'(LANE) * LANE_STEP;
   localparam logic [WIDTH-1:0] SEED_L    = SEED ^ WIDTH'(LANE);
   localparam logic [WIDTH-1:0] SEED_INIT = (SEED_L == '0) ? WIDTH'(1) : SEED_L;
   localparam logic [WIDTH-1:0] TAPS      = WIDTH'(LFSR_TAPS);

   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] gen_next;
   logic [WIDTH-1:0] pattern;
   logic             phase;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
      pattern  = phase ? ALT_B : ALT_A;
      gen_next = gen;
      case (mode)
         MODE_INC: begin
            pattern  = gen;
            gen_next = gen + WIDTH'(1);
         end
         MODE_LFSR: begin
            pattern  = gen;
            gen_next = {gen[WIDTH-2:0], ^(gen & TAPS)};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         // NOTE: state updates use <= so every register samples pre-edge values regardless of block order.
         gen   <= '0;
         phase <= 1'b0;
         data  <= '0;
      end else if (init) begin
         gen   <= (mode == MODE_LFSR) ? SEED_INIT : WIDTH'(LANE);
         phase <= 1'b0;
      end else if (step) begin
         data  <= en ? pattern : '0;
         phase <= ~phase;
         gen   <= gen_next;
      end
   end

endmodule

// File: rtl/phy_lane_stim_gen.sv
// Multi-lane stimulus source: start/stop controller, word-rate divider and
// burst counter driving one pattern generator per lane.
module phy_lane_stim_gen
   import phy_stim_pkg::*;
#(
   parameter int               NUM_LANES = 4,
   parameter int               WIDTH     = 8,
   parameter int               DIV       = 32,
   parameter int               CNT_W     = 16,
   parameter logic [WIDTH-1:0] PAT_A     = 8'hAA,
   parameter logic [WIDTH-1:0] PAT_B     = 8'hBB,
   parameter logic [WIDTH-1:0] LANE_STEP = 8'h22,
   parameter logic [WIDTH-1:0] SEED      = 8'hA5
) (
   input  logic                       clk_32f,
   input  logic                       reset_L,
   input  logic                       start,
   input  logic                       stop,
   input  logic [1:0]                 mode,
   input  logic [CNT_W-1:0]           burst_len,
   input  logic [NUM_LANES-1:0]       lane_en,
   output logic [NUM_LANES*WIDTH-1:0] data_out,
   output logic [NUM_LANES-1:0]       valid_out,
   output logic                       word_stb,
   output logic                       busy,
   output logic                       done
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [1:0]           state;
   logic [DIV_W-1:0]     div;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     burst_q;
   logic [NUM_LANES-1:0] lane_en_q;
   logic [1:0]           mode_q;
   logic [1:0]           lane_mode;
   logic                 stop_q;
   logic                 start_acc;
   logic                 tick;
   logic                 finish;

   assign start_acc = (state == ST_IDLE) && start;
   assign tick      = (state == ST_RUN) && (div == DIV_W'(DIV - 1));
   assign finish    = stop_q || ((burst_q != '0) && (count == burst_q));
   // The boundary that ends a burst presents no new word, so it gets no strobe.
   assign word_stb  = tick && !finish;
   assign busy      = (state == ST_RUN);
   assign done      = (state == ST_DONE);
   // Generators seed on the accept edge, before mode_q holds the new mode.
   assign lane_mode = start_acc ? mode : mode_q;

   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         state     <= ST_IDLE;
         div       <= '0;
         count     <= '0;
         burst_q   <= '0;
         lane_en_q <= '0;
         mode_q    <= MODE_ALT;
         stop_q    <= 1'b0;
         valid_out <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_RUN;
                  div       <= '0;
                  count     <= '0;
                  stop_q    <= 1'b0;
                  mode_q    <= mode;
                  burst_q   <= burst_len;
                  lane_en_q <= lane_en;
               end
            end
            ST_RUN: begin
               div <= tick ? '0 : div + DIV_W'(1);
               if (stop) stop_q <= 1'b1;
               if (tick) begin
                  if (finish) begin
                     valid_out <= '0;
                     state     <= ST_DONE;
                  end else begin
                     valid_out <= lane_en_q;
                     count     <= count + CNT_W'(1);
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      phy_lane_pattern #(
         .WIDTH     (WIDTH),
         .LANE      (i),
         .PAT_A     (PAT_A),
         .PAT_B     (PAT_B),
         .LANE_STEP (LANE_STEP),
         .SEED      (SEED)
      ) u_lane (
         .clk_32f (clk_32f),
         .reset_L (reset_L),
         .init    (start_acc),
         .step    (word_stb),
         .en      (lane_en_q[i]),
         .mode    (lane_mode),
         .data    (data_out[i*WIDTH +: WIDTH])
      );
   end

endmodule

// File: tb/tb_phy_lane_stim_gen.sv
// Randomised bench for phy_lane_stim_gen against a word-level reference model;
// a second instance covers the fast-divider, eight-lane configuration.
module tb_phy_lane_stim_gen;

   localparam int DIV  = 32;
   localparam int DIV6 = 4;

   logic        clk_32f = 1'b0;
   logic        reset_L;

   logic        start, stop;
   logic [1:0]  mode;
   logic [15:0] burst_len;
   logic [3:0]  lane_en;
   logic [31:0] data_out;
   logic [3:0]  valid_out;
   logic        word_stb, busy, done;

   logic        start6, stop6;
   logic [1:0]  mode6;
   logic [15:0] burst6;
   logic [7:0]  lane_en6;
   logic [63:0] data6;
   logic [7:0]  valid6;
   logic        stb6, busy6, done6;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] hold_data;

   always #5 clk_32f = ~clk_32f;

   phy_lane_stim_gen dut (
      .clk_32f   (clk_32f),
      .reset_L   (reset_L),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .burst_len (burst_len),
      .lane_en   (lane_en),
      .data_out  (data_out),
      .valid_out (valid_out),
      .word_stb  (word_stb),
      .busy      (busy),
      .done      (done)
   );

   phy_lane_stim_gen #(.NUM_LANES(8), .DIV(DIV6)) dut6 (
      .clk_32f   (clk_32f),
      .reset_L   (reset_L),
      .start     (start6),
      .stop      (stop6),
      .mode      (mode6),
      .burst_len (burst6),
      .lane_en   (lane_en6),
      .data_out  (data6),
      .valid_out (valid6),
      .word_stb  (stb6),
      .busy      (busy6),
      .done      (done6)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Lane value for word k, straight from the pattern definitions.
   function automatic logic [7:0] pat(input logic [1:0] m, input int i, input int k);
      logic [7:0] s;
      case (m)
         2'd1: return 8'((i + k) % 256);
         2'd2: begin
            s = 8'(8'hA5 ^ i);
            if (s == 8'h00) s = 8'h01;
            for (int j = 0; j < k; j++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
            return s;
         end
         default: return (k % 2 == 0) ? 8'(8'hAA + 8'h22 * i) : 8'(8'hBB + 8'h22 * i);
      endcase
   endfunction

   function automatic logic [31:0] word(input logic [1:0] m, input logic [3:0] en, input int k);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 4; i++) if (en[i]) w[i*8 +: 8] = pat(m, i, k);
      return w;
   endfunction

   // Entered and left on a negedge with the DUT idle. stop_cyc < 0: no stop.
   task automatic run_burst(input string tag, input logic [1:0] m, input int blen,
                            input logic [3:0] en, input int stop_cyc,
                            input bit poke_start, input bit start_with_stop);
      int nwords, ns, end_n, n_stb;
      logic [31:0] exp_d;
      logic [3:0]  exp_v;
      ns     = (stop_cyc >= 0) ? ((stop_cyc + 2 + DIV - 1) / DIV) - 1 : 1 << 30;
      nwords = (blen == 0) ? ns : ((blen < ns) ? blen : ns);
      end_n  = DIV * (nwords + 1);
      n_stb  = 0;
      start = 1'b1; mode = m; burst_len = 16'(blen); lane_en = en; stop = start_with_stop;
      @(negedge clk_32f);
      for (int n = 0; n <= end_n + 1; n++) begin
         if (n >= DIV && n < end_n) begin
            exp_d = word(m, en, n / DIV - 1);
            exp_v = en;
         end else if (n >= end_n) begin
            exp_d = word(m, en, nwords - 1);
            exp_v = '0;
         end else begin
            exp_d = hold_data;
            exp_v = '0;
         end
         check({tag, "_data"},  data_out,  exp_d);
         check({tag, "_valid"}, valid_out, exp_v);
         check({tag, "_stb"},   word_stb,  ((n + 1) % DIV == 0) && ((n + 1) / DIV <= nwords));
         check({tag, "_busy"},  busy,      n < end_n);
         check({tag, "_done"},  done,      n == end_n);
         if (word_stb) n_stb++;
         start = poke_start && (n == DIV + 3);
         stop  = (n == stop_cyc);
         if (n == 0) begin
            mode      = 2'($urandom_range(0, 3));
            burst_len = 16'($urandom_range(1, 9));
            lane_en   = 4'($urandom_range(0, 15));
         end
         @(negedge clk_32f);
      end
      start = 1'b0;
      stop  = 1'b0;
      check({tag, "_stb_count"}, n_stb, nwords);
      hold_data = word(m, en, nwords - 1);
   endtask

   initial begin
      int stbs, vcyc, w, end6, sc;
      logic [63:0] exp6;
      logic [7:0]  expv6;

      reset_L = 1'b0;
      start = 0; stop = 0; mode = 0; burst_len = 0; lane_en = 0;
      start6 = 0; stop6 = 0; mode6 = 0; burst6 = 0; lane_en6 = 0;
      hold_data = '0;
      repeat (3) @(negedge clk_32f);
      check("rst_data", data_out, 0);
      check("rst_valid", valid_out, 0);
      check("rst_ctrl", {word_stb, busy, done}, 0);
      check("rst_data6", data6, 0);
      reset_L = 1'b1;
      @(negedge clk_32f);

      // Asynchronous reset in the middle of a continuous burst
      start = 1; mode = 2'd1; burst_len = 0; lane_en = 4'hF;
      @(negedge clk_32f);
      start = 0;
      repeat (40) @(negedge clk_32f);
      check("pre_rst_busy", busy, 1);
      check("pre_rst_valid", valid_out, 4'hF);
      reset_L = 1'b0;
      #1;
      check("arst_data", data_out, 0);
      check("arst_valid", valid_out, 0);
      check("arst_ctrl", {word_stb, busy, done}, 0);
      repeat (3) begin
         @(negedge clk_32f);
         check("arst_hold", {word_stb, busy, done}, 0);
      end
      reset_L = 1'b1;
      hold_data = '0;
      @(negedge clk_32f);

      run_burst("alt4",    2'd0, 4, 4'hF,    -1,           0, 0);
      run_burst("inc_stop",2'd1, 0, 4'hF,    DIV * 11 + 5, 0, 0);
      run_burst("lfsr3",   2'd2, 3, 4'b0101, -1,           0, 0);
      run_burst("restart", 2'd3, 3, 4'hF,    -1,           1, 1);
      run_burst("after",   2'd1, 2, 4'b1010, -1,           0, 0);
      repeat (6) begin
         sc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(DIV, DIV * 6)) : -1;
         run_burst("rand", 2'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                   4'($urandom_range(1, 15)), sc, 1'($urandom_range(0, 1)), 0);
      end

      // Fast divider, eight lanes, long INC burst through the 8-bit wrap
      start6 = 1; mode6 = 2'd1; burst6 = 16'd300; lane_en6 = 8'hFF;
      @(negedge clk_32f);
      start6 = 0;
      stbs = 0; vcyc = 0;
      end6 = DIV6 * 301;
      for (int n = 0; n <= end6 + 1; n++) begin
         w = (n >= end6) ? 299 : n / DIV6 - 1;
         exp6  = '0;
         expv6 = (n >= DIV6 && n < end6) ? 8'hFF : 8'h00;
         if (n >= DIV6) for (int i = 0; i < 8; i++) exp6[i*8 +: 8] = 8'((i + w) % 256);
         check("d6_data",  data6,  exp6);
         check("d6_valid", valid6, expv6);
         check("d6_stb",   stb6,   ((n + 1) % DIV6 == 0) && ((n + 1) / DIV6 <= 300));
         check("d6_done",  done6,  n == end6);
         if (n == DIV6 * 257) check("d6_wrap", data6[7:0], 8'h00);
         if (stb6) stbs++;
         if (valid6 != 8'h00) vcyc++;
         @(negedge clk_32f);
      end
      check("d6_stb_count", stbs, 300);
      check("d6_valid_words", vcyc / DIV6, 300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
